// File: rtl/uart_pkg.sv
// Shared UART definitions: line-format codes, oversampling ratio and the
// receiver state encoding used by uart_rx and its helpers.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int STOP_1   = 1;
  localparam int STOP_2   = 2;
  localparam int STOP_1P5 = 3;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_DONE   = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_tick_gen.sv
// 16x-baud tick generator; held at phase zero while clear is high so the
// first tick after release is aligned to the detected start edge.
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, mid-bit sampling LSB first, optional
// parity and first-stop-bit check, one-clock valid strobe with held flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_BIT = 0,
  parameter int DATA_LEN   = 8,
  parameter int STOP_BIT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic [DATA_LEN-1:0] data,
  output logic                data_valid,
  output logic                parity_err,
  output logic                frame_err,
  output logic                rx_busy
);

  if (DATA_LEN < 5 || DATA_LEN > 9) begin : g_bad_len
    $error("uart_rx: DATA_LEN must be in 5..9");
  end
  if (STOP_BIT < STOP_1 || STOP_BIT > STOP_1P5) begin : g_bad_stop
    $error("uart_rx: STOP_BIT must be 1, 2 or 3");
  end

  localparam int BCW = $clog2(DATA_LEN);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_LEN - 1);
  localparam logic [3:0]     MID_START = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]     MID_BIT   = 4'(OVERSAMPLE - 1);

  rx_state_e           state, state_next;
  logic                rx_m, rx_s;
  logic [1:0]          sync_fill;
  logic                armed;
  logic                tick, mid_bit, parity_expected;
  logic [3:0]          scnt;
  logic [BCW-1:0]      bit_cnt;
  logic [DATA_LEN-1:0] shift;
  logic                perr_int, ferr_int;

  // sync_fill marks when the preset synchroniser contents have been flushed,
  // so a line held low through reset is never mistaken for a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  uart_rx_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state == RX_IDLE),
    .tick  (tick)
  );

  assign mid_bit = tick && (scnt == ((state == RX_START) ? MID_START : MID_BIT));
  assign parity_expected = (PARITY_BIT == PARITY_ODD) ? ~^shift : ^shift;
  assign rx_busy = (state != RX_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RX_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:   if (armed && !rx_s) state_next = RX_START;
      RX_START:  if (mid_bit) state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:   if (mid_bit && bit_cnt == LAST_BIT)
                   state_next = (PARITY_BIT != PARITY_NONE) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (mid_bit) state_next = RX_STOP;
      RX_STOP:   if (mid_bit) state_next = RX_DONE;
      RX_DONE:   state_next = RX_IDLE;
      default:   state_next = RX_IDLE;
    endcase
  end

  // The 4-bit tick counter wraps 15->0 on its own between data/parity/stop bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt       <= '0;
      bit_cnt    <= '0;
      armed      <= 1'b0;
      perr_int   <= 1'b0;
      ferr_int   <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      armed      <= (state == RX_IDLE) && (armed || (sync_fill[1] && rx_s));
      data_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          scnt     <= '0;
          bit_cnt  <= '0;
          perr_int <= 1'b0;
          ferr_int <= 1'b0;
        end
        RX_START:  if (tick) scnt <= mid_bit ? 4'd0 : scnt + 4'd1;
        RX_DATA: begin
          if (tick)    scnt    <= scnt + 4'd1;
          if (mid_bit) bit_cnt <= bit_cnt + 1'b1;
        end
        RX_PARITY: begin
          if (tick)    scnt     <= scnt + 4'd1;
          if (mid_bit) perr_int <= (rx_s != parity_expected);
        end
        RX_STOP: begin
          if (tick)    scnt     <= scnt + 4'd1;
          if (mid_bit) ferr_int <= ~rx_s;
        end
        RX_DONE: begin
          data       <= shift;
          parity_err <= perr_int;
          frame_err  <= ferr_int;
          data_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RX_DATA && mid_bit) shift <= {rx_s, shift[DATA_LEN-1:1]};
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 and an 8O1 receiver driven by directed frames,
// checked against a frame-level expectation queue and literal values.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_n = 1'b1;
  logic rx_o = 1'b1;
  logic [7:0] data_n, data_o;
  logic dv_n, dv_o, pe_n, pe_o, fe_n, fe_o, busy_n, busy_o;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY_BIT(0), .DATA_LEN(8), .STOP_BIT(1)) dut_n (
    .clk(clk), .rst(rst), .rx(rx_n), .data(data_n), .data_valid(dv_n),
    .parity_err(pe_n), .frame_err(fe_n), .rx_busy(busy_n));

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY_BIT(1), .DATA_LEN(8), .STOP_BIT(1)) dut_o (
    .clk(clk), .rst(rst), .rx(rx_o), .data(data_o), .data_valid(dv_o),
    .parity_err(pe_o), .frame_err(fe_o), .rx_busy(busy_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         fall;
    int         par;
  } exp_t;

  exp_t       q[2][$];
  logic [7:0] hold_d[2];
  logic       hold_pe[2];
  logic       hold_fe[2];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame-level model: every valid pops one expected frame; otherwise outputs hold.
  always @(negedge clk) begin
    logic [7:0] d[2];
    logic v[2], p[2], f[2], b[2];
    exp_t e;
    int lat, ctr;
    d[0] = data_n; v[0] = dv_n; p[0] = pe_n; f[0] = fe_n; b[0] = busy_n;
    d[1] = data_o; v[1] = dv_o; p[1] = pe_o; f[1] = fe_o; b[1] = busy_o;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        chk("reset outputs", {d[k], v[k], p[k], f[k], b[k]} == 12'd0, {d[k], v[k], p[k], f[k], b[k]}, 0);
        hold_d[k] = 8'h00; hold_pe[k] = 1'b0; hold_fe[k] = 1'b0;
      end else if (v[k]) begin
        if (q[k].size() == 0) begin
          chk("unexpected data_valid", 1'b0, d[k], 0);
        end else begin
          e = q[k].pop_front();
          chk("frame data", d[k] == e.d, d[k], e.d);
          chk("frame parity_err", p[k] == e.pe, p[k], e.pe);
          chk("frame frame_err", f[k] == e.fe, f[k], e.fe);
          lat = cyc - e.fall;
          ctr = (1 + 8 + e.par) * BIT + BIT / 2 + 3;
          chk("frame latency", lat >= ctr - 6 && lat <= ctr + 6, lat, ctr);
          hold_d[k] = e.d; hold_pe[k] = e.pe; hold_fe[k] = e.fe;
        end
      end else begin
        chk("held outputs", d[k] == hold_d[k] && p[k] == hold_pe[k] && f[k] == hold_fe[k],
            {d[k], p[k], f[k]}, {hold_d[k], hold_pe[k], hold_fe[k]});
      end
    end
  end

  task automatic drive(input int k, input logic v, input int n);
    if (k == 0) rx_n = v;
    else        rx_o = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic pbit, input logic stopv);
    exp_t e;
    e.d    = d;
    e.par  = k;
    e.pe   = (k == 1) ? ((^{d, pbit}) == 1'b0) : 1'b0;
    e.fe   = ~stopv;
    e.fall = cyc;
    q[k].push_back(e);
    drive(k, 1'b0, BIT);
    chk("busy during frame", ((k == 0) ? busy_n : busy_o) == 1'b1, (k == 0) ? busy_n : busy_o, 1);
    for (int i = 0; i < 8; i++) drive(k, d[i], BIT);
    if (k == 1) drive(k, pbit, BIT);
    drive(k, stopv, BIT);
  endtask

  task automatic drain(input int k, input int budget);
    int n = 0;
    while (q[k].size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n > 0) #1;
    chk("frame arrived in time", q[k].size() == 0, q[k].size(), 0);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    drive(0, 1'b1, 10);

    // 8N1 0xA5
    send(0, 8'hA5, 1'b0, 1'b1);
    drain(0, 300);
    chk("s1 data literal", data_n == 8'hA5, data_n, 8'hA5);
    chk("s1 flags literal", {pe_n, fe_n} == 2'b00, {pe_n, fe_n}, 0);

    // 8O1 0x03, correct then wrong parity bit
    send(1, 8'h03, 1'b1, 1'b1);
    drain(1, 300);
    chk("s2 good parity literal", pe_o == 1'b0, pe_o, 0);
    send(1, 8'h03, 1'b0, 1'b1);
    drain(1, 300);
    chk("s2 bad parity data literal", data_o == 8'h03, data_o, 8'h03);
    chk("s2 bad parity flag literal", pe_o == 1'b1, pe_o, 1);

    // break: stop bit low, line held low
    send(0, 8'h00, 1'b0, 1'b0);
    drive(0, 1'b0, 40);
    drain(0, 300);
    chk("s3 frame_err literal", fe_n == 1'b1, fe_n, 1);
    chk("s3 idle while low", busy_n == 1'b0, busy_n, 0);
    drive(0, 1'b1, 20);
    send(0, 8'hC3, 1'b0, 1'b1);
    drain(0, 300);
    chk("s3 recovery literal", {data_n, fe_n} == {8'hC3, 1'b0}, {data_n, fe_n}, {8'hC3, 1'b0});

    // 4-clk glitch
    drive(0, 1'b1, 10);
    drive(0, 1'b0, 4);
    chk("s4 busy on glitch", busy_n == 1'b1, busy_n, 1);
    drive(0, 1'b1, 10);
    chk("s4 busy dropped", busy_n == 1'b0, busy_n, 0);
    drive(0, 1'b1, 20);
    send(0, 8'h5A, 1'b0, 1'b1);
    drain(0, 300);
    chk("s4 data literal", data_n == 8'h5A, data_n, 8'h5A);

    // back-to-back frames
    send(0, 8'h11, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b1);
    send(0, 8'h33, 1'b0, 1'b1);
    drain(0, 300);
    chk("s5 last data literal", data_n == 8'h33, data_n, 8'h33);

    // reset during data bit 3 of 0xFF, released with line low
    drive(0, 1'b1, 10);
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, BIT);
    drive(0, 1'b1, BIT / 2);
    rst = 1'b0;
    #1;
    chk("s6 async reset literal", {data_n, dv_n, pe_n, fe_n, busy_n} == 12'd0,
        {data_n, dv_n, pe_n, fe_n, busy_n}, 0);
    rx_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    drive(0, 1'b0, 30);
    chk("s6 no start while low", busy_n == 1'b0, busy_n, 0);
    drive(0, 1'b1, 20);
    send(0, 8'h3C, 1'b0, 1'b1);
    drain(0, 300);
    chk("s6 data literal", data_n == 8'h3C, data_n, 8'h3C);

    drive(0, 1'b1, 200);
    chk("no pending frames", q[0].size() + q[1].size() == 0, q[0].size() + q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
